sram_arbiter: RTL

//  Shares the single SRAM controller between instruction fetch (IF, read-only) and data memory (MEM) ports.

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arb_watchdog.sv | 37 +++
 rtl/sram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared opcodes and arbiter state encoding for the SRAM arbiter slice.
// MEM_* values are the opcodes understood by the SRAM controller; 0 means idle.
package sram_arbiter_pkg;

  localparam int ADDR_W = 20;
  localparam int WORD_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] MEM_NOP = 4'h0;
  localparam logic [OP_W-1:0] MEM_LW  = 4'h1;
  localparam logic [OP_W-1:0] MEM_LH  = 4'h2;
  localparam logic [OP_W-1:0] MEM_LB  = 4'h3;
  localparam logic [OP_W-1:0] MEM_LHU = 4'h4;
  localparam logic [OP_W-1:0] MEM_LBU = 4'h5;
  localparam logic [OP_W-1:0] MEM_SW  = 4'h6;
  localparam logic [OP_W-1:0] MEM_SH  = 4'h7;
  localparam logic [OP_W-1:0] MEM_SB  = 4'h8;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_BUSY_IF  = 3'd1,
    ARB_BUSY_MEM = 3'd2,
    ARB_GAP_IF   = 3'd3,
    ARB_GAP_MEM  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sram_arb_watchdog.sv
// Access watchdog: counts cycles while enabled and flags the cycle in which the
// TIMEOUT_CYC-th enabled cycle is reached, so the arbiter can abort the access.
module sram_arb_watchdog #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk50,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clr_i) begin
      wd_cnt_d = '0;
    end else if (en_i && (wd_cnt_q != CW'(TIMEOUT_CYC))) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Fires while the count being added this cycle is the TIMEOUT_CYC-th one.
  assign expire_o = en_i && (wd_cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the single SRAM controller between instruction fetch and data memory.
// One access at a time; every access passes IDLE -> BUSY -> GAP so the controller sees an idle cycle.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int IF_STARVE_MAX = 4,
  parameter int TIMEOUT_CYC   = 15
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [WORD_W-1:0] if_data_o,
  output logic              if_ready_o,
  output logic              if_stall_o,
  input  logic [OP_W-1:0]   mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [WORD_W-1:0] mem_wdata_i,
  output logic [WORD_W-1:0] mem_data_o,
  output logic              mem_ready_o,
  output logic              mem_stall_o,
  output logic [OP_W-1:0]   ram_op_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [WORD_W-1:0] ram_wdata_o,
  input  logic [WORD_W-1:0] ram_rdata_i,
  input  logic              ram_success_i,
  output logic              err_o
);

  localparam int SW = $clog2(IF_STARVE_MAX + 1);

  arb_state_e        state_q;
  logic [SW-1:0]     starve_q;
  logic [OP_W-1:0]   ram_op_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [WORD_W-1:0] ram_wdata_q, if_data_q, mem_data_q;
  logic              if_ready_q, mem_ready_q, err_q;
  logic              mem_pend, grant_if, grant_mem, busy, wd_expire;

  assign mem_pend = (mem_op_i != MEM_NOP);
  assign busy     = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_MEM);

  // MEM wins a tie unless IF has already been passed over IF_STARVE_MAX times.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (mem_pend && if_req_i) begin
        grant_if  = (starve_q == SW'(IF_STARVE_MAX));
        grant_mem = !grant_if;
      end else begin
        grant_if  = if_req_i;
        grant_mem = mem_pend;
      end
    end
  end

  sram_arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk50    (clk50),
    .rst      (rst),
    .clr_i    (state_q == ARB_IDLE),
    .en_i     (busy),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      ram_op_q    <= MEM_NOP;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;

      if (!if_req_i || grant_if) begin
        starve_q <= '0;
      end else if (grant_mem && (starve_q != SW'(IF_STARVE_MAX))) begin
        starve_q <= starve_q + 1'b1;
      end

      case (state_q)
        ARB_IDLE: begin
          if (grant_if) begin
            ram_op_q    <= MEM_LW;
            ram_addr_q  <= if_addr_i;
            ram_wdata_q <= '0;
            state_q     <= ARB_BUSY_IF;
          end else if (grant_mem) begin
            ram_op_q    <= mem_op_i;
            ram_addr_q  <= mem_addr_i;
            ram_wdata_q <= mem_wdata_i;
            state_q     <= ARB_BUSY_MEM;
          end
        end
        ARB_BUSY_IF: begin
          if (ram_success_i || wd_expire) begin
            if_data_q  <= ram_success_i ? ram_rdata_i : '0;
            err_q      <= !ram_success_i;
            if_ready_q <= 1'b1;
            ram_op_q   <= MEM_NOP;
            state_q    <= ARB_GAP_IF;
          end
        end
        ARB_BUSY_MEM: begin
          if (ram_success_i || wd_expire) begin
            mem_data_q  <= ram_success_i ? ram_rdata_i : '0;
            err_q       <= !ram_success_i;
            mem_ready_q <= 1'b1;
            ram_op_q    <= MEM_NOP;
            state_q     <= ARB_GAP_MEM;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign ram_op_o    = ram_op_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;
  assign if_ready_o  = if_ready_q;
  assign mem_ready_o = mem_ready_q;
  assign err_o       = err_q;
  assign if_stall_o  = if_req_i & ~if_ready_q;
  assign mem_stall_o = mem_pend & ~mem_ready_q;

endmodule
